io_input_conditioner: RTL and testbench

//  Conditions raw board inputs (10 slide switches, 4 push keys) before they reach the data

---
 rtl/io_pkg.sv | 15 +
 rtl/io_input_conditioner_if.sv | 22 ++
 rtl/io_input_conditioner_debounce_bit.sv | 50 +++++
 rtl/io_input_conditioner.sv | 80 ++++++++
 tb/tb_io_input_conditioner.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared IO-path constants used by the input conditioner and the data memory's IO read path.
package io_pkg;

   localparam int   IO_DEBOUNCE_DEFAULT = 50000;
   localparam int   NUM_SW_DEFAULT      = 10;
   localparam int   NUM_KEY_DEFAULT     = 4;
   localparam logic KEY_IDLE            = 1'b1;
   localparam logic SW_RESET            = 1'b0;

   // Counter must be able to hold 0..cycles without wrapping.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// Board-input bus between the raw pins and the data memory's IO read path.
interface io_input_conditioner_if #(
   parameter int NUM_SW  = io_pkg::NUM_SW_DEFAULT,
   parameter int NUM_KEY = io_pkg::NUM_KEY_DEFAULT
);
   logic [NUM_SW-1:0]  swRaw;
   logic [NUM_KEY-1:0] keyRaw;
   logic [NUM_KEY-1:0] clrKeys;
   logic [NUM_SW-1:0]  switches;
   logic [NUM_KEY-1:0] keys;
   logic [NUM_KEY-1:0] keyPress;

   modport master (
      output swRaw, keyRaw, clrKeys,
      input  switches, keys, keyPress
   );

   modport slave (
      input  swRaw, keyRaw, clrKeys,
      output switches, keys, keyPress
   );
endinterface

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a restart-on-glitch debounce counter.
module debounce_bit
   import io_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic stable_o
);
   localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= RESET_VAL;
         s2_q     <= RESET_VAL;
         stable_q <= RESET_VAL;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronise, debounce and edge-detect board switches/keys for the data memory's IO path.
// Define KEY_STICKY_EN to turn keys into sticky active-high press flags cleared by clrKeys.
module io_input_conditioner
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
   parameter int NUM_SW          = NUM_SW_DEFAULT,
   parameter int NUM_KEY         = NUM_KEY_DEFAULT
) (
   input logic                   clk,
   input logic                   reset,
   io_input_conditioner_if.slave io
);
   logic [NUM_SW-1:0]  sw_stable;
   logic [NUM_KEY-1:0] key_stable;
   logic [NUM_KEY-1:0] key_prev_q;
   logic [NUM_KEY-1:0] key_press_q, key_press_d;

   for (genvar g = 0; g < NUM_SW; g++) begin : gen_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (SW_RESET)
      ) u_db (
         .clk      (clk),
         .reset    (reset),
         .raw_i    (io.swRaw[g]),
         .stable_o (sw_stable[g])
      );
   end

   for (genvar g = 0; g < NUM_KEY; g++) begin : gen_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (KEY_IDLE)
      ) u_db (
         .clk      (clk),
         .reset    (reset),
         .raw_i    (io.keyRaw[g]),
         .stable_o (key_stable[g])
      );
   end

   // Keys are active-low: a press is a debounced 1->0 transition.
   assign key_press_d = key_prev_q & ~key_stable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_prev_q  <= {NUM_KEY{KEY_IDLE}};
         key_press_q <= '0;
      end else begin
         key_prev_q  <= key_stable;
         key_press_q <= key_press_d;
      end
   end

   assign io.switches = sw_stable;
   assign io.keyPress = key_press_q;

`ifdef KEY_STICKY_EN
   logic [NUM_KEY-1:0] sticky_q, sticky_d;

   // A press arriving in the same cycle as a clear keeps the flag set.
   assign sticky_d = key_press_d | (sticky_q & ~io.clrKeys);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign io.keys = sticky_q;
`else
   logic unused_clr;
   assign unused_clr = ^io.clrKeys;
   assign io.keys    = key_stable;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed vector table, multi-cycle corner sequences, and
// randomized stimulus against a window-based reference model. Honours KEY_STICKY_EN.
module tb_io_input_conditioner;
   import io_pkg::*;

   localparam int          DC      = 4;
   localparam int          NSW     = 10;
   localparam int          NKEY    = 4;
   localparam logic [13:0] RST_VEC = {4'hF, 10'h000};

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int checks = 0;
   int errors = 0;

   io_input_conditioner_if #(.NUM_SW(NSW), .NUM_KEY(NKEY)) io_bus ();

   io_input_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .NUM_SW          (NSW),
      .NUM_KEY         (NKEY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io_bus)
   );

   always #5 clk = ~clk;

   // Reference model: a bit commits once the last DC observations (raw delayed two edges)
   // all disagree with the current level and DC edges have passed since its last commit.
   logic [13:0] samp_q[$];
   logic [13:0] obs_q[$];
   logic [13:0] m_stable;
   int          since_commit[14];
   int          fall_edge[4];
   int          edge_n;
   logic [3:0]  m_press;
   logic [3:0]  m_flag;

   function automatic void model_reset();
      samp_q = {RST_VEC, RST_VEC};
      obs_q  = {};
      m_stable = RST_VEC;
      foreach (since_commit[b]) since_commit[b] = DC;
      foreach (fall_edge[k]) fall_edge[k] = -10;
      edge_n  = 0;
      m_press = '0;
      m_flag  = '0;
   endfunction

   function automatic void model_edge();
      logic [13:0] obs;
      logic [13:0] prev;
      logic        all_diff;
      edge_n++;
      samp_q.push_back({io_bus.keyRaw, io_bus.swRaw});
      obs = samp_q[samp_q.size() - 3];
      if (samp_q.size() > 3) void'(samp_q.pop_front());
      obs_q.push_back(obs);
      if (obs_q.size() > DC) void'(obs_q.pop_front());
      prev = m_stable;
      for (int b = 0; b < 14; b++) begin
         since_commit[b]++;
         if (obs_q.size() == DC && since_commit[b] >= DC) begin
            all_diff = 1'b1;
            foreach (obs_q[j]) if (obs_q[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_stable[b]     = ~m_stable[b];
               since_commit[b] = 0;
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         m_press[k] = (fall_edge[k] == edge_n - 1);
         if (prev[10+k] && !m_stable[10+k]) fall_edge[k] = edge_n;
         m_flag[k] = m_press[k] | (m_flag[k] & ~io_bus.clrKeys[k]);
      end
   endfunction

   function automatic logic [3:0] model_keys();
`ifdef KEY_STICKY_EN
      return m_flag;
`else
      return m_stable[13:10];
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [9:0] sw, input logic [3:0] key, input logic [3:0] clr);
      io_bus.swRaw   = sw;
      io_bus.keyRaw  = key;
      io_bus.clrKeys = clr;
   endtask

   // Advance n rising edges; returns on the following falling edge for sampling/driving.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!reset) model_reset();
         else        model_edge();
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [9:0] sw;
      logic [3:0] key;
      logic [3:0] clr;
      int         cycles;
      logic [9:0] exp_sw;
      logic [3:0] exp_lvl;
      logic [3:0] exp_stk;
      logic [3:0] exp_press;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] cur;
      logic [3:0]  ek;

      vecs[0] = '{sw:10'h201, key:4'hF, clr:4'h0, cycles:5, exp_sw:10'h000, exp_lvl:4'hF, exp_stk:4'h0, exp_press:4'h0};
      vecs[1] = '{sw:10'h201, key:4'hF, clr:4'h0, cycles:1, exp_sw:10'h201, exp_lvl:4'hF, exp_stk:4'h0, exp_press:4'h0};
      vecs[2] = '{sw:10'h201, key:4'hB, clr:4'h0, cycles:6, exp_sw:10'h201, exp_lvl:4'hB, exp_stk:4'h0, exp_press:4'h0};
      vecs[3] = '{sw:10'h201, key:4'hB, clr:4'h0, cycles:1, exp_sw:10'h201, exp_lvl:4'hB, exp_stk:4'h4, exp_press:4'h4};
      vecs[4] = '{sw:10'h201, key:4'hB, clr:4'h0, cycles:1, exp_sw:10'h201, exp_lvl:4'hB, exp_stk:4'h4, exp_press:4'h0};
      vecs[5] = '{sw:10'h201, key:4'hF, clr:4'hB, cycles:6, exp_sw:10'h201, exp_lvl:4'hF, exp_stk:4'h4, exp_press:4'h0};
      vecs[6] = '{sw:10'h201, key:4'hF, clr:4'h0, cycles:1, exp_sw:10'h201, exp_lvl:4'hF, exp_stk:4'h4, exp_press:4'h0};
      vecs[7] = '{sw:10'h000, key:4'hF, clr:4'h4, cycles:6, exp_sw:10'h000, exp_lvl:4'hF, exp_stk:4'h0, exp_press:4'h0};

`ifdef KEY_STICKY_EN
      ek = 4'h0;
`else
      ek = 4'hF;
`endif

      // Reset held with every raw input opposite to its idle level.
      reset = 1'b0;
      drive(10'h3FF, 4'h0, 4'h0);
      model_reset();
      tick(3);
      check("reset_switches", io_bus.switches, 10'h000);
      check("reset_keys", io_bus.keys, ek);
      check("reset_keypress", io_bus.keyPress, 4'h0);
      drive(10'h000, 4'hF, 4'h0);
      reset = 1'b1;
      tick(2);

      foreach (vecs[i]) begin
         drive(vecs[i].sw, vecs[i].key, vecs[i].clr);
         tick(vecs[i].cycles);
`ifdef KEY_STICKY_EN
         ek = vecs[i].exp_stk;
`else
         ek = vecs[i].exp_lvl;
`endif
         check($sformatf("vec%0d_switches", i), io_bus.switches, vecs[i].exp_sw);
         check($sformatf("vec%0d_keys", i), io_bus.keys, ek);
         check($sformatf("vec%0d_keypress", i), io_bus.keyPress, vecs[i].exp_press);
      end

      // Glitch shorter than the debounce window is rejected; a full window is accepted.
      drive(10'h001, 4'hF, 4'h0);
      tick(3);
      drive(10'h000, 4'hF, 4'h0);
      tick(8);
      check("glitch3_sw0", io_bus.switches[0], 1'b0);
      drive(10'h001, 4'hF, 4'h0);
      tick(4);
      drive(10'h000, 4'hF, 4'h0);
      tick(1);
      check("glitch4_sw0_early", io_bus.switches[0], 1'b0);
      tick(1);
      check("glitch4_sw0_commit", io_bus.switches[0], 1'b1);
      tick(6);
      check("glitch4_sw0_return", io_bus.switches[0], 1'b0);

      // Asynchronous reset part-way through a count, then a fresh full count.
      drive(10'h201, 4'hF, 4'h0);
      tick(6);
      check("premid_switches", io_bus.switches, 10'h201);
      drive(10'h203, 4'hF, 4'h0);
      tick(4);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("midreset_switches", io_bus.switches, 10'h000);
      check("midreset_keypress", io_bus.keyPress, 4'h0);
      tick(1);
      reset = 1'b1;
      tick(5);
      check("postreset_early", io_bus.switches, 10'h000);
      tick(1);
      check("postreset_commit", io_bus.switches, 10'h203);

`ifdef KEY_STICKY_EN
      drive(10'h203, 4'hD, 4'h0);
      tick(7);
      check("sticky_set", io_bus.keys, 4'h2);
      check("sticky_pulse", io_bus.keyPress, 4'h2);
      tick(1);
      check("sticky_pulse_end", io_bus.keyPress, 4'h0);
      drive(10'h203, 4'hF, 4'h0);
      tick(10);
      check("sticky_hold", io_bus.keys, 4'h2);
      drive(10'h203, 4'hF, 4'h2);
      tick(1);
      check("sticky_clear", io_bus.keys, 4'h0);
      drive(10'h203, 4'hD, 4'h0);
      tick(6);
      drive(10'h203, 4'hD, 4'h2);
      tick(1);
      check("sticky_set_wins", io_bus.keys, 4'h2);
      check("sticky_set_wins_pulse", io_bus.keyPress, 4'h2);
      drive(10'h203, 4'hD, 4'h0);
      tick(1);
      check("sticky_set_wins_hold", io_bus.keys, 4'h2);
      drive(10'h203, 4'hF, 4'h0);
      tick(8);
`endif

      for (int c = 0; c < 2000; c++) begin
         cur = {io_bus.keyRaw, io_bus.swRaw};
         for (int b = 0; b < 14; b++) begin
            if ($urandom_range(7) == 0) cur[b] = ~cur[b];
         end
         drive(cur[9:0], cur[13:10], 4'($urandom_range(15)) & 4'($urandom_range(15)));
         tick(1);
         check($sformatf("rand%0d", c), {io_bus.switches, io_bus.keys, io_bus.keyPress},
               {m_stable[9:0], model_keys(), m_press});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
